// File: rtl/loop_filter_pi.sv
// PI loop filter for QAM16 carrier/timing recovery; drives the NCO frequency word.
// Decimated integrator with power-of-two gains, saturating integrator and output.
module loop_filter_pi #(
    parameter int DW          = 34,
    parameter int SHW         = 5,
    parameter int PERIOD_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] pd,
    input  logic [SHW-1:0]       ki_sh,
    input  logic [SHW-1:0]       kp_sh,
    input  logic                 hold,
    input  logic                 clr_int,
    output logic signed [DW-1:0] fd_out,
    output logic                 fd_valid,
    output logic                 int_sat
);

    localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    // Shift amounts past DW-1 collapse to the sign, so clamp instead of wrapping.
    function automatic logic signed [DW-1:0] asr(input logic signed [DW-1:0] x,
                                                 input logic [SHW-1:0] s);
        int si;
        si = int'(s);
        if (si > DW-1) si = DW-1;
        return x >>> si;
    endfunction

    function automatic logic signed [DW:0] add_ext(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
        return $signed({a[DW-1], a}) + $signed({b[DW-1], b});
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] s);
        if (s[DW] != s[DW-1]) return s[DW] ? MINV : MAXV;
        return s[DW-1:0];
    endfunction

    logic [PERIOD_LOG2-1:0] cnt;
    logic signed [DW-1:0]   integ, pd_q, integ_eff, integ_nx, fd_nx;
    logic signed [DW:0]     isum, osum;
    logic                   iclip;

    always_comb begin
        isum      = add_ext(integ, asr(pd, ki_sh));
        integ_nx  = sat(isum);
        iclip     = isum[DW] != isum[DW-1];
        // A clear on the output edge must already be visible to the output adder.
        integ_eff = clr_int ? '0 : integ;
        osum      = add_ext(integ_eff, asr(pd_q, kp_sh));
        fd_nx     = sat(osum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            integ    <= '0;
            pd_q     <= '0;
            fd_out   <= '0;
            fd_valid <= 1'b0;
            int_sat  <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;
            fd_valid <= (cnt == PERIOD_LOG2'(1));
            if (cnt == '0) pd_q <= pd;
            if (clr_int) begin
                integ   <= '0;
                int_sat <= 1'b0;
            end else if (cnt == '0 && !hold) begin
                integ   <= integ_nx;
                int_sat <= iclip;
            end
            if (cnt == PERIOD_LOG2'(1)) fd_out <= fd_nx;
        end
    end

endmodule

// File: tb/tb_loop_filter_pi.sv
// Directed bench for loop_filter_pi: period-level model feeds a queue of
// expected output words, popped whenever fd_valid is seen.
module tb_loop_filter_pi;
    localparam int DW = 34;
    localparam int SHW = 5;
    localparam int P = 8;
    localparam longint MAXV = (longint'(1) <<< 33) - 1;
    localparam longint MINV = -(longint'(1) <<< 33);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [DW-1:0] pd = '0;
    logic [SHW-1:0]       ki_sh = '0, kp_sh = '0;
    logic                 hold = 1'b0, clr_int = 1'b0;
    logic signed [DW-1:0] fd_out;
    logic                 fd_valid, int_sat;

    loop_filter_pi #(.DW(DW), .SHW(SHW), .PERIOD_LOG2(3)) dut (
        .clk(clk), .rst(rst), .pd(pd), .ki_sh(ki_sh), .kp_sh(kp_sh),
        .hold(hold), .clr_int(clr_int), .fd_out(fd_out),
        .fd_valid(fd_valid), .int_sat(int_sat)
    );

    always #5 clk = ~clk;

    typedef struct { longint fd; bit sat; } exp_t;
    exp_t   sb[$];
    int     total = 0, bad = 0;
    bit     exp_vld = 1'b0;
    longint m_integ = 0;
    bit     m_sat = 1'b0;

    function automatic longint m_asr(longint x, int s);
        if (s > DW-1) s = DW-1;
        return x >>> s;
    endfunction

    function automatic longint m_sat_v(longint v);
        return (v > MAXV) ? MAXV : (v < MINV) ? MINV : v;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: strobe timing every cycle, and word/flag whenever a strobe shows up.
    always @(negedge clk) begin
        exp_t e;
        longint fo;
        chk("fd_valid_timing", longint'(fd_valid), longint'(exp_vld));
        if (fd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e  = sb.pop_front();
                fo = longint'(fd_out);
                chk("sb_fd_out", fo, e.fd);
                chk("sb_int_sat", longint'(int_sat), longint'(e.sat));
            end
        end
    end

    task automatic do_reset(input bit check);
        rst = 1'b0; pd = '0; hold = 1'b0; clr_int = 1'b0;
        m_integ = 0; m_sat = 1'b0; exp_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        if (check) begin
            chk("rst_fd_out", longint'(fd_out), 0);
            chk("rst_fd_valid", longint'(fd_valid), 0);
            chk("rst_int_sat", longint'(int_sat), 0);
        end
        rst = 1'b1;
    endtask

    // One update period; clr_at / rst_at select the cnt at which to pulse (-1 = never).
    task automatic run_period(input longint pdv, input int ki, input int kp,
                              input bit hd, input int clr_at, input int rst_at);
        longint s;
        exp_t e;
        for (int k = 0; k < P; k++) begin
            pd = DW'(pdv); ki_sh = SHW'(ki); kp_sh = SHW'(kp);
            hold = hd; clr_int = (k == clr_at);
            if (k == rst_at) begin
                rst = 1'b0;
                #1;
                chk("midrst_fd_out", longint'(fd_out), 0);
                chk("midrst_fd_valid", longint'(fd_valid), 0);
                chk("midrst_int_sat", longint'(int_sat), 0);
                m_integ = 0; m_sat = 1'b0; exp_vld = 1'b0; clr_int = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                return;
            end
            if (k == 0) begin
                if (clr_int) begin
                    m_integ = 0; m_sat = 1'b0;
                end else if (!hd) begin
                    s = m_integ + m_asr(pdv, ki);
                    m_sat = (s > MAXV) || (s < MINV);
                    m_integ = m_sat_v(s);
                end
            end else if (clr_int) begin
                m_integ = 0; m_sat = 1'b0;
            end
            if (k == 1) begin
                e.fd = m_sat_v(m_integ + m_asr(pdv, kp));
                e.sat = m_sat;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            exp_vld = (k == 1);
        end
        clr_int = 1'b0;
    endtask

    initial begin
        // 1: reset values, then first strobe on the second edge
        do_reset(1'b1);

        // 2: constant positive input
        run_period(16384, 14, 6, 0, -1, -1); chk("t2_fd0", longint'(fd_out), 257);
        run_period(16384, 14, 6, 0, -1, -1); chk("t2_fd1", longint'(fd_out), 258);
        run_period(16384, 14, 6, 0, -1, -1); chk("t2_fd2", longint'(fd_out), 259);
        chk("t2_int_sat", longint'(int_sat), 0);

        // 3: floor shift of negative input
        do_reset(1'b0);
        run_period(-1, 14, 6, 0, -1, -1); chk("t3_fd0", longint'(fd_out), -2);
        run_period(-1, 14, 6, 0, -1, -1); chk("t3_fd1", longint'(fd_out), -3);
        run_period(-1, 14, 6, 0, -1, -1); chk("t3_fd2", longint'(fd_out), -4);

        // 4: saturation both ways
        do_reset(1'b0);
        run_period(MAXV, 0, 0, 0, -1, -1); chk("t4_fd_pos0", longint'(fd_out), MAXV);
        chk("t4_sat0", longint'(int_sat), 0);
        run_period(MAXV, 0, 0, 0, -1, -1); chk("t4_fd_pos1", longint'(fd_out), MAXV);
        chk("t4_sat1", longint'(int_sat), 1);
        run_period(MINV, 0, 0, 0, -1, -1); chk("t4_fd_neg0", longint'(fd_out), MINV);
        run_period(MINV, 0, 0, 0, -1, -1); chk("t4_fd_neg1", longint'(fd_out), MINV);
        chk("t4_sat_neg", longint'(int_sat), 1);

        // 5: hold, clear mid-period, clear together with hold
        do_reset(1'b0);
        repeat (10) run_period(16384, 14, 6, 0, -1, -1);
        chk("t5_pre_hold", longint'(fd_out), 266);
        run_period(16384, 14, 6, 1, -1, -1); chk("t5_hold0", longint'(fd_out), 266);
        run_period(16384, 14, 6, 1, -1, -1); chk("t5_hold1", longint'(fd_out), 266);
        run_period(16384, 14, 6, 1, 5, -1);
        run_period(16384, 14, 6, 1, -1, -1); chk("t5_after_clr", longint'(fd_out), 256);
        chk("t5_clr_sat", longint'(int_sat), 0);
        run_period(16384, 14, 6, 0, -1, -1); chk("t5_regrow", longint'(fd_out), 257);
        run_period(16384, 14, 6, 1, 0, -1); chk("t5_clr_hold", longint'(fd_out), 256);

        // 6: mid-period reset, then shift clamping
        run_period(16384, 14, 6, 0, -1, -1);
        run_period(16384, 14, 6, 0, -1, 4);
        run_period(-5, 31, 31, 0, -1, -1); chk("t6_clamp0", longint'(fd_out), -2);
        run_period(-5, 31, 31, 0, -1, -1); chk("t6_clamp1", longint'(fd_out), -3);
        run_period(-5, 31, 31, 0, -1, -1); chk("t6_clamp2", longint'(fd_out), -4);

        @(negedge clk);
        chk("sb_drained", longint'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
